dsd_operand_sequencer: RTL and testbench

- Upstream feeder for the 16-bit double/clear datapath stage. That stage has a `reg_a`/`reg_b` pair, a select mux, and an add/subtract `out_reg`.
- Accepts operand+opcode words over a valid/ready handshake and buffers them in a small FIFO.
- Drives the datapath's `in`, `sel_1_2` and `sel_3` inputs, holding each operand and its selects stable for a fixed settle window so the two-cycle datapath captures them cleanly.

---
 rtl/dsd_operand_sequencer.sv | 134 +++++++++++++
 tb/tb_dsd_operand_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsd_operand_sequencer.sv
// Operand sequencer feeding the 16-bit double/clear datapath: buffers {op, data}
// words in a small FIFO and presents each one, with its selects, for a fixed settle window.
module dsd_operand_sequencer #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [1:0]                 in_op,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       sel_1_2,
    output logic                       sel_3,
    output logic                       issue,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SETTLE
    } state_t;

    state_t           state;
    logic [SW-1:0]    settle_cnt;
    logic [WIDTH+1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH+1:0] head;
    logic             push;
    logic             pop;
    logic             nonempty;

    assign in_ready   = (count < FULL_COUNT);
    assign fifo_count = count;
    assign nonempty   = (count != '0);
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr];

    // The head is only taken from IDLE or on the last settle cycle, so a word
    // pushed this edge is never visible to the same-edge pop decision.
    assign pop = nonempty &&
                 ((state == ST_IDLE) ||
                  ((state == ST_SETTLE) && (settle_cnt == SW'(1))));

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_op, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequencing FSM; operand and selects only move on a pop edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            issue      <= 1'b0;
            busy       <= 1'b0;
            out_data   <= '0;
            sel_1_2    <= 1'b0;
            sel_3      <= 1'b0;
        end else begin
            issue <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state <= ST_ISSUE;
                        issue <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state      <= ST_SETTLE;
                    settle_cnt <= SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    if (settle_cnt == SW'(1)) begin
                        if (pop) begin
                            state <= ST_ISSUE;
                            issue <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (pop) begin
                out_data <= head[WIDTH-1:0];
                sel_1_2  <= head[WIDTH];
                sel_3    <= head[WIDTH+1];
            end
        end
    end

endmodule

// File: tb/tb_dsd_operand_sequencer.sv
// Self-checking bench for dsd_operand_sequencer: directed steps plus random traffic
// compared against a schedule model (issue time = max(push+1, previous issue+SETTLE+1)).
module tb_dsd_operand_sequencer;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 2;

    logic                       clk;
    logic                       rst_n;
    logic [WIDTH-1:0]           in_data;
    logic [1:0]                 in_op;
    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH-1:0]           out_data;
    logic                       sel_1_2;
    logic                       sel_3;
    logic                       issue;
    logic                       busy;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    dsd_operand_sequencer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .SETTLE(SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .sel_1_2   (sel_1_2),
        .sel_3     (sel_3),
        .issue     (issue),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run  = 0;
    int fail_count = 0;

    // Model: each accepted word gets a scheduled issue cycle when pushed.
    int               cyc = 0;
    int               q_time[$];
    logic [17:0]      q_word[$];
    int               m_count;
    int               last_sched;
    int               last_issue;
    bit               m_issue;
    bit               m_busy;
    logic [WIDTH-1:0] m_data;
    logic             m_s12;
    logic             m_s3;

    task automatic modelReset();
        q_time.delete();
        q_word.delete();
        m_count    = 0;
        last_sched = -100;
        last_issue = -100;
        m_issue    = 0;
        m_busy     = 0;
        m_data     = '0;
        m_s12      = 1'b0;
        m_s3       = 1'b0;
    endtask

    task automatic modelStep(input logic v, input logic [WIDTH-1:0] d, input logic [1:0] op,
                             output bit acc);
        int          prev;
        int          t;
        logic [17:0] w;
        acc = 0;
        cyc++;
        if (!rst_n) begin
            modelReset();
            return;
        end
        prev    = m_count;
        m_issue = 0;
        if (q_time.size() > 0 && q_time[0] == cyc) begin
            void'(q_time.pop_front());
            w          = q_word.pop_front();
            m_data     = w[15:0];
            m_s12      = w[16];
            m_s3       = w[17];
            m_issue    = 1;
            last_issue = cyc;
            m_count--;
        end
        if (v && prev < DEPTH) begin
            t = cyc + 1;
            if (last_sched + SETTLE + 1 > t) t = last_sched + SETTLE + 1;
            q_time.push_back(t);
            q_word.push_back({op, d});
            last_sched = t;
            m_count++;
            acc = 1;
        end
        m_busy = (cyc < last_issue + SETTLE + 1);
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
        end
    endtask

    task automatic checkOutput();
        checkValue("in_ready",   {31'd0, in_ready},   {31'd0, (m_count < DEPTH)});
        checkValue("fifo_count", {29'd0, fifo_count}, m_count);
        checkValue("issue",      {31'd0, issue},      {31'd0, m_issue});
        checkValue("busy",       {31'd0, busy},       {31'd0, m_busy});
        checkValue("out_data",   {16'd0, out_data},   {16'd0, m_data});
        checkValue("sel_1_2",    {31'd0, sel_1_2},    {31'd0, m_s12});
        checkValue("sel_3",      {31'd0, sel_3},      {31'd0, m_s3});
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic [1:0] op,
                                 output bit acc);
        in_valid = v;
        in_data  = d;
        in_op    = op;
        @(posedge clk);
        modelStep(v, d, op, acc);
        #1;
        checkOutput();
    endtask

    // Offers one word until the model says it was taken; a stall past the bound is a failure.
    task automatic pushWord(input logic [WIDTH-1:0] d, input logic [1:0] op);
        bit acc;
        acc = 0;
        for (int k = 0; k < 40 && !acc; k++) begin
            applyStimulus(1'b1, d, op, acc);
        end
        if (!acc) checkValue("push_stall", 32'd0, 32'd1);
    endtask

    task automatic idleCycles(input int n);
        bit acc;
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 16'($urandom), 2'($urandom), acc);
        end
    endtask

    initial begin
        bit acc;
        logic [WIDTH-1:0] vals [4];
        int seen_peak;

        modelReset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        in_op    = 2'b11;

        // Reset held with a valid word offered: nothing may be taken.
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 16'($urandom), 2'($urandom), acc);
        rst_n = 1'b1;
        idleCycles(2);

        // Single word.
        pushWord(16'h0002, 2'b00);
        idleCycles(6);

        // Back-to-back pushes; peak occupancy should reach three.
        vals[0] = 16'd3; vals[1] = 16'd1; vals[2] = 16'd0; vals[3] = 16'd5;
        seen_peak = 0;
        for (int k = 0; k < 4; k++) begin
            pushWord(vals[k], 2'b00);
            if (int'(fifo_count) > seen_peak) seen_peak = int'(fifo_count);
        end
        checkValue("b2b_peak", seen_peak, 32'd3);
        idleCycles(12);

        // Continuous pushes beyond capacity exercise the full stall.
        for (int k = 0; k < 6; k++) pushWord(16'h0100 + 16'(k), 2'(k));
        idleCycles(20);

        // Opcode pass-through with all-ones data.
        for (int k = 0; k < 4; k++) pushWord(16'hFFFF, 2'(k));
        idleCycles(14);

        // Gapped traffic so both pointers wrap at least twice.
        for (int k = 0; k < 10; k++) begin
            pushWord(16'($urandom), 2'($urandom));
            idleCycles($urandom_range(0, 4));
        end
        idleCycles(30);
        checkValue("wrap_drained", {29'd0, fifo_count}, 32'd0);

        // Random traffic.
        for (int k = 0; k < 150; k++) begin
            applyStimulus(($urandom_range(0, 99) < 55), 16'($urandom), 2'($urandom), acc);
        end
        idleCycles(20);

        // Asynchronous reset in the middle of a settle window.
        pushWord(16'hA5A5, 2'b11);
        pushWord(16'h5A5A, 2'b10);
        idleCycles(2);
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        for (int k = 0; k < 2; k++) applyStimulus(1'b1, 16'($urandom), 2'($urandom), acc);
        rst_n = 1'b1;
        idleCycles(4);
        pushWord(16'h0042, 2'b01);
        idleCycles(8);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
